spi_word_sequencer: RTL and testbench
=====================================

Name:
spi_word_sequencer

Overview:
- Parametrised successor to the single-purpose three-word DAC loader. Serialises a programmable-length sequence of WORD_WIDTH-bit words onto a 3-wire SPI-style bus (fsync/sclk/sdata), MSB first.
- Each word is framed by its own fsync-low window. Clock polarity, word width, word count and inter-word gap are all configurable.
- Sits between control FSMs and serial peripherals (DDS, DAC, PLL) that need multi-register writes.

Parameters:
- WORD_WIDTH, 16: bits per word.
- NUM_WORDS, 3: maximum words per frame. Must be ≥1.
- CLKS_PER_BIT, 10: clk cycles per serial bit. Must be ≥2 and even.
- CPOL, 1: sclk idle level.
- FSYNC_GAP, 20: clk cycles fsync is held high after each word.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request, level-sampled.
- words  in  NUM_WORDS*WORD_WIDTH  word k at [k*WORD_WIDTH +: WORD_WIDTH]; word 0 is sent first.
- num_words  in  $clog2(NUM_WORDS+1)  words to send; 0 or >NUM_WORDS means NUM_WORDS.
- go_ack  out  1  one-cycle pulse when go is accepted.
- busy  out  1  high while a frame is in progress.
- send_complete  out  1  one-cycle pulse at frame end.
- fsync  out  1  frame sync, active low.
- sclk  out  1  serial clock.
- sdata  out  1  serial data.

Behaviour:
- Reset values: go_ack=0, busy=0, send_complete=0, fsync=1, sclk=CPOL, sdata=0, state=IDLE, all counters 0.
- rst at any time, including mid-frame, restores these values at the next edge. No partial-word completion.
- States: IDLE, LEAD, SHIFT, GAP, DONE.
- IDLE:
  - On go=1, latch words and num_words into shadow regs.
  - Pulse go_ack, set busy=1, go to LEAD.
  - go while busy is ignored; the shadow regs are not disturbed.
- LEAD: fsync=0, sclk=CPOL, lasts CLKS_PER_BIT cycles, then go to SHIFT.
- SHIFT:
  - Runs WORD_WIDTH bit periods of CLKS_PER_BIT cycles each.
  - Phase 0 of each period: sdata <= current bit (MSB first), sclk <= CPOL.
  - Phase CLKS_PER_BIT/2: sclk <= ~CPOL. For CPOL=1 this falling edge is the sampling edge; data has been stable for CLKS_PER_BIT/2 cycles.
  - After the last phase of the last bit, go to GAP.
- GAP:
  - First cycle: fsync <= 1, sclk <= CPOL, sdata <= 0. Lasts FSYNC_GAP cycles.
  - Then: if word_idx == count-1, go to DONE; else word_idx++ and go to LEAD.
- DONE: send_complete pulses for 1 cycle. busy drops on the same edge that ends the pulse, i.e. busy is low on the cycle after send_complete. Then go to IDLE.
- Frame length: count*(CLKS_PER_BIT*(WORD_WIDTH+1)+FSYNC_GAP) cycles from the go-accept edge to the DONE edge.
- Counters:
  - Phase counter width $clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1.
  - bit_idx wraps at WORD_WIDTH-1.
  - No counter exceeds its declared width for any legal parameter set.
- go held high continuously: a new frame starts on the first IDLE cycle after DONE. Back-to-back frames are separated by exactly 1 IDLE cycle.

Optional Feature:
- Macro: SPI_SEQ_REPEAT_EN.
- With the macro defined:
  - Extra input repeat (1 bit).
  - At the end of the last GAP, if repeat=1: pulse send_complete, re-latch words/num_words, and go directly to LEAD with word_idx=0. busy stays high and there is no IDLE cycle.
  - If repeat=0, the normal DONE path is taken.
- Without the macro: the port is absent and behaviour is identical to repeat=0.

Decomposition:
- Package spi_seq_pkg holds:
  - the state enum (IDLE, LEAD, SHIFT, GAP, DONE);
  - the width-derivation functions/localparams (phase, bit, word counter widths);
  - the default timing constants.
- Sub-module spi_bit_timer:
  - Free-running-when-enabled phase counter with CLKS_PER_BIT parameter.
  - Outputs strobes phase0, phase_half and phase_last.
  - Clear input restarts at phase 0.

Test Plan:
- Default params, num_words=3, words={16'h4000,16'h50C7,16'h2100} (word0=16'h2100):
  - go pulse yields go_ack on the next cycle.
  - Three fsync-low windows of 170 cycles each.
  - sdata sampled at each sclk falling edge reconstructs 2100, 50C7, 4000.
  - send_complete at cycle 570 after accept.
- num_words=1, and separately num_words=0:
  - 1 yields exactly one fsync window and send_complete 190 cycles after accept.
  - 0 behaves identically to num_words=3.
- go held high for 2 frames: second go_ack exactly 1 cycle after busy falls; words changed during frame 1 do not appear until frame 2.
- rst asserted at cycle 95 of word 1 SHIFT: next cycle fsync=1, sclk=1, busy=0, sdata=0. A subsequent go produces a clean full frame.
- CPOL=0, WORD_WIDTH=24, CLKS_PER_BIT=4: sclk idles low; sampling on falling edges reconstructs 24'hA5C33C. LEAD+SHIFT window is 100 cycles.
- SPI_SEQ_REPEAT_EN, repeat=1 for 2 frames then 0:
  - Two send_complete pulses with no busy drop between them.
  - The third frame ends with busy falling.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for spi_word_sequencer.
//   seq_state_t  - frame sequencer states
//   DEF_*        - default timing/geometry constants
//   cnt_width()  - counter width for a counter that must hold 0..n-1
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_WORD_WIDTH   = 16;
    localparam int unsigned DEF_NUM_WORDS    = 3;
    localparam int unsigned DEF_CLKS_PER_BIT = 10;
    localparam bit          DEF_CPOL         = 1'b1;
    localparam int unsigned DEF_FSYNC_GAP    = 20;

    // Never returns 0 so degenerate sizes still give a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// spi_bit_timer: phase counter for one serial bit period.
//   clk, rst    - clock, synchronous active-high reset
//   en          - advance the phase counter this cycle
//   clear       - force the counter back to phase 0
//   phase0      - counter will be at phase 0 in the next cycle
//   phase_half  - counter will be at phase CLKS_PER_BIT/2 in the next cycle
//   phase_last  - counter is at phase CLKS_PER_BIT-1 now
// phase0/phase_half look one cycle ahead so registered outputs driven from
// them change exactly on the phase boundary.
module spi_bit_timer
    import spi_seq_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic phase0,
    output logic phase_half,
    output logic phase_last
);

    localparam int unsigned        PHASE_W = cnt_width(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] HALF    = PHASE_W'(CLKS_PER_BIT / 2);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;

    always_comb begin
        phase_nxt = phase;
        if (rst || clear) begin
            phase_nxt = '0;
        end else if (en) begin
            phase_nxt = (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase_nxt;
        end
    end

    assign phase_last = (phase == LAST);
    assign phase0     = (phase_nxt == '0);
    assign phase_half = (phase_nxt == HALF);

endmodule

// File: rtl/spi_word_sequencer.sv
// spi_word_sequencer: serialises up to NUM_WORDS words, MSB first, each in
// its own fsync-low window, onto a 3-wire SPI-style bus.
//   clk, rst       - clock, synchronous active-high reset
//   go             - start request (level sampled in IDLE)
//   repeat_frame   - (SPI_SEQ_REPEAT_EN only) restart frame without IDLE
//   words          - word k at [k*WORD_WIDTH +: WORD_WIDTH], word 0 first
//   num_words      - words per frame; 0 or >NUM_WORDS means NUM_WORDS
//   go_ack         - one-cycle pulse when go is accepted
//   busy           - frame in progress
//   send_complete  - one-cycle pulse at frame end
//   fsync, sclk, sdata - serial bus
// Optional feature macro: SPI_SEQ_REPEAT_EN.
module spi_word_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit          CPOL         = DEF_CPOL,
    parameter int unsigned FSYNC_GAP    = DEF_FSYNC_GAP
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
`ifdef SPI_SEQ_REPEAT_EN
    // 'repeat' is a reserved word, hence the longer name.
    input  logic                              repeat_frame,
`endif
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]   words,
    input  logic [$clog2(NUM_WORDS+1)-1:0]    num_words,
    output logic                              go_ack,
    output logic                              busy,
    output logic                              send_complete,
    output logic                              fsync,
    output logic                              sclk,
    output logic                              sdata
);

    localparam int unsigned CNT_W = cnt_width(NUM_WORDS + 1);
    localparam int unsigned BIT_W = cnt_width(WORD_WIDTH);
    localparam int unsigned GAP_W = cnt_width(FSYNC_GAP);

    seq_state_t            state, state_next;
    logic [WORD_WIDTH-1:0] shadow [NUM_WORDS];
    logic [WORD_WIDTH-1:0] cur_word;
    logic [WORD_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]      count, eff_count, word_idx;
    logic [BIT_W-1:0]      bit_idx;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  accept, restart, gap_end, last_word, bit_last;
    logic                  phase0, phase_half, phase_last, run, rpt;

`ifdef SPI_SEQ_REPEAT_EN
    assign rpt = repeat_frame;
`else
    assign rpt = 1'b0;
`endif

    assign run = (state == LEAD) || (state == SHIFT);

    spi_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .clear      (!run),
        .phase0     (phase0),
        .phase_half (phase_half),
        .phase_last (phase_last)
    );

    always_comb begin
        eff_count = num_words;
        if (num_words == '0 || num_words > CNT_W'(NUM_WORDS)) begin
            eff_count = CNT_W'(NUM_WORDS);
        end
    end

    always_comb begin
        cur_word = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (word_idx == CNT_W'(k)) begin
                cur_word = shadow[k];
            end
        end
    end

    assign gap_end   = (state == GAP) && (gap_cnt == GAP_W'(FSYNC_GAP - 1));
    assign last_word = (word_idx == count - 1'b1);
    assign bit_last  = (bit_idx == BIT_W'(WORD_WIDTH - 1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE:  if (go) begin
                       accept     = 1'b1;
                       state_next = LEAD;
                   end
            LEAD:  if (phase_last) state_next = SHIFT;
            SHIFT: if (phase_last && bit_last) state_next = GAP;
            GAP:   if (gap_end) begin
                       if (!last_word) begin
                           state_next = LEAD;
                       end else if (rpt) begin
                           restart    = 1'b1;
                           state_next = LEAD;
                       end else begin
                           state_next = DONE;
                       end
                   end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state and the timer's
    // look-ahead strobes so they switch on the boundary they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            go_ack        <= 1'b0;
            busy          <= 1'b0;
            send_complete <= 1'b0;
            fsync         <= 1'b1;
            sclk          <= CPOL;
            sdata         <= 1'b0;
            sreg          <= '0;
            count         <= '0;
            word_idx      <= '0;
            bit_idx       <= '0;
            gap_cnt       <= '0;
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state         <= state_next;
            go_ack        <= accept;
            busy          <= (state_next != IDLE);
            send_complete <= (state_next == DONE) || restart;
            fsync         <= !((state_next == LEAD) || (state_next == SHIFT));

            if (accept || restart) begin
                for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                    shadow[k] <= words[k*WORD_WIDTH +: WORD_WIDTH];
                end
                count    <= eff_count;
                word_idx <= '0;
            end else if (gap_end && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end else if (state == DONE) begin
                word_idx <= '0;
            end

            if (state == SHIFT && phase_last) begin
                bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
            end

            gap_cnt <= (state == GAP && state_next == GAP) ? gap_cnt + 1'b1 : '0;

            if (state_next == SHIFT && phase_half) begin
                sclk <= ~CPOL;
            end else if (state_next != SHIFT || phase0) begin
                sclk <= CPOL;
            end

            if (state_next != SHIFT) begin
                sdata <= 1'b0;
            end else if (phase0) begin
                if (state == LEAD) begin
                    sdata <= cur_word[WORD_WIDTH-1];
                    sreg  <= cur_word << 1;
                end else begin
                    sdata <= sreg[WORD_WIDTH-1];
                    sreg  <= sreg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_word_sequencer.sv
module tb_spi_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        go0, go1;
    logic [47:0] words0;
    logic [1:0]  num0;
    logic [23:0] words1;
    logic        num1;
    logic        go_ack0, busy0, sc0, fsync0, sclk0, sdata0;
    logic        go_ack1, busy1, sc1, fsync1, sclk1, sdata1;
`ifdef SPI_SEQ_REPEAT_EN
    logic        rpt0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    localparam logic [47:0] W1 = {16'h4000, 16'h50C7, 16'h2100};
    localparam logic [47:0] W2 = {16'h1111, 16'h2222, 16'h3333};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_word_sequencer #(
        .WORD_WIDTH(16), .NUM_WORDS(3), .CLKS_PER_BIT(10), .CPOL(1'b1), .FSYNC_GAP(20)
    ) u0 (
        .clk(clk), .rst(rst), .go(go0),
`ifdef SPI_SEQ_REPEAT_EN
        .repeat_frame(rpt0),
`endif
        .words(words0), .num_words(num0), .go_ack(go_ack0), .busy(busy0),
        .send_complete(sc0), .fsync(fsync0), .sclk(sclk0), .sdata(sdata0)
    );

    spi_word_sequencer #(
        .WORD_WIDTH(24), .NUM_WORDS(1), .CLKS_PER_BIT(4), .CPOL(1'b0), .FSYNC_GAP(20)
    ) u1 (
        .clk(clk), .rst(rst), .go(go1),
`ifdef SPI_SEQ_REPEAT_EN
        .repeat_frame(1'b0),
`endif
        .words(words1), .num_words(num1), .go_ack(go_ack1), .busy(busy1),
        .send_complete(sc1), .fsync(fsync1), .sclk(sclk1), .sdata(sdata1)
    );

    // Bus monitors: a peripheral samples sdata as it was just before sclk falls.
    int unsigned win_q[$], ack_q[$], sc_q[$], bfall_q[$];
    logic [31:0] word_q[$];
    logic        p_fs0 = 1'b1, p_sclk0 = 1'b1, p_sd0 = 1'b0, p_busy0 = 1'b0;
    int unsigned wlen0 = 0;
    logic [31:0] rx0 = '0;

    always @(negedge clk) begin
        if (go_ack0) ack_q.push_back(cyc);
        if (sc0) sc_q.push_back(cyc);
        if (p_busy0 && !busy0) bfall_q.push_back(cyc);
        if (p_fs0 && !fsync0) begin rx0 = '0; wlen0 = 0; end
        if (!fsync0) wlen0++;
        if (p_sclk0 && !sclk0) rx0 = {rx0[30:0], p_sd0};
        if (!p_fs0 && fsync0) begin
            win_q.push_back(wlen0);
            word_q.push_back(rx0);
            wlen0 = 0;
        end
        p_fs0 = fsync0; p_sclk0 = sclk0; p_sd0 = sdata0; p_busy0 = busy0;
    end

    logic        p_fs1 = 1'b1, p_sclk1 = 1'b0, p_sd1 = 1'b0;
    int unsigned wlen1 = 0, win1 = 0, ack1_cyc = 0, sc1_cyc = 0;
    logic [31:0] rx1 = '0, word1 = '0;

    always @(negedge clk) begin
        if (go_ack1) ack1_cyc = cyc;
        if (sc1) sc1_cyc = cyc;
        if (p_fs1 && !fsync1) begin rx1 = '0; wlen1 = 0; end
        if (!fsync1) wlen1++;
        if (p_sclk1 && !sclk1) rx1 = {rx1[30:0], p_sd1};
        if (!p_fs1 && fsync1) begin win1 = wlen1; word1 = rx1; wlen1 = 0; end
        p_fs1 = fsync1; p_sclk1 = sclk1; p_sd1 = sdata1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        win_q.delete(); ack_q.delete(); sc_q.delete(); bfall_q.delete(); word_q.delete();
    endtask

    task automatic start0(input string tag, input logic [1:0] nw, input logic [47:0] w);
        clear_q();
        words0 = w;
        num0   = nw;
        go0    = 1'b1;
        tick();
        go0    = 1'b0;
        chk({tag, " go_ack"}, {31'd0, go_ack0}, 32'd1);
        tick();
        chk({tag, " go_ack pulse"}, {31'd0, go_ack0}, 32'd0);
    endtask

    task automatic wait_idle0(input string tag);
        int unsigned n = 0;
        while (busy0 && n < 3000) begin tick(); n++; end
        chk({tag, " idle"}, {31'd0, busy0}, 32'd0);
    endtask

    task automatic check_words(input string tag, input int unsigned n, input logic [95:0] exp);
        chk({tag, " windows"}, win_q.size(), n);
        for (int i = 0; i < int'(n); i++) begin
            chk($sformatf("%s win%0d", tag, i), win_q[i], 32'd170);
            chk($sformatf("%s word%0d", tag, i), word_q[i], {16'd0, exp[i*16 +: 16]});
        end
    endtask

    task automatic frame0(input string tag, input logic [1:0] nw, input int unsigned n,
                          input int unsigned dur);
        start0(tag, nw, W1);
        wait_idle0(tag);
        check_words(tag, n, {48'd0, W1});
        chk({tag, " sc time"}, sc_q[0] - ack_q[0], dur);
        chk({tag, " busy drop"}, bfall_q[0] - sc_q[0], 32'd1);
    endtask

    initial begin
        int unsigned a;
        rst = 1'b1; go0 = 1'b0; go1 = 1'b0;
        words0 = W1; num0 = 2'd3; words1 = 24'hA5C33C; num1 = 1'b1;
`ifdef SPI_SEQ_REPEAT_EN
        rpt0 = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset u0", {26'd0, go_ack0, busy0, sc0, fsync0, sclk0, sdata0}, 32'b000110);
        chk("reset u1", {26'd0, go_ack1, busy1, sc1, fsync1, sclk1, sdata1}, 32'b000100);

        frame0("nw3", 2'd3, 3, 570);
        frame0("nw1", 2'd1, 1, 190);
        frame0("nw0", 2'd0, 3, 570);

        // go held high across two frames; words change during frame 1
        clear_q();
        words0 = W1; num0 = 2'd3; go0 = 1'b1;
        tick();
        chk("hold go_ack", {31'd0, go_ack0}, 32'd1);
        words0 = W2;
        for (int i = 0; i < 1500; i++) begin
            if (ack_q.size() >= 2) break;
            tick();
        end
        go0 = 1'b0;
        chk("hold ack2 seen", ack_q.size(), 32'd2);
        wait_idle0("hold");
        check_words("hold", 6, {W2, W1});
        chk("hold ack gap", ack_q[1] - bfall_q[0], 32'd1);
        chk("hold frame1 sc", sc_q[0] - ack_q[0], 32'd570);

        // reset during word 1, SHIFT cycle 95
        start0("rst", 2'd3, W1);
        a = ack_q[0];
        for (int i = 0; i < 400; i++) begin
            if (cyc >= a + 295) break;
            tick();
        end
        chk("rst pre fsync", {31'd0, fsync0}, 32'd0);
        chk("rst pre sclk", {31'd0, sclk0}, 32'd0);
        chk("rst pre windows", win_q.size(), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst mid", {26'd0, go_ack0, busy0, sc0, fsync0, sclk0, sdata0}, 32'b000110);
        rst = 1'b0;
        tick();
        frame0("post rst", 2'd3, 3, 570);

        // CPOL=0, 24-bit words, 4 clocks per bit
        go1 = 1'b1;
        tick();
        go1 = 1'b0;
        chk("u1 go_ack", {31'd0, go_ack1}, 32'd1);
        for (int i = 0; i < 500; i++) begin
            if (!busy1) break;
            tick();
        end
        chk("u1 idle", {31'd0, busy1}, 32'd0);
        chk("u1 window", win1, 32'd100);
        chk("u1 word", word1, 32'h00A5C33C);
        chk("u1 sc time", sc1_cyc - ack1_cyc, 32'd120);
        chk("u1 sclk idle", {31'd0, sclk1}, 32'd0);

`ifdef SPI_SEQ_REPEAT_EN
        rpt0 = 1'b1;
        start0("rpt", 2'd1, W1);
        for (int i = 0; i < 1000; i++) begin
            if (sc_q.size() >= 2) break;
            tick();
        end
        rpt0 = 1'b0;
        wait_idle0("rpt");
        chk("rpt sc count", sc_q.size(), 32'd3);
        chk("rpt busy drops", bfall_q.size(), 32'd1);
        chk("rpt sc spacing", sc_q[1] - sc_q[0], 32'd190);
        chk("rpt sc total", sc_q[2] - sc_q[0], 32'd380);
        chk("rpt busy end", bfall_q[0] - sc_q[2], 32'd1);
        chk("rpt windows", win_q.size(), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
